// File: rtl/ro_100_pkg.sv
// ro_100_pkg: shared types and constants for the RO_100 gated edge counter.
// Optional feature macro used by this slice: RO_GATE_BOTH_EDGES_EN
// (count both tap edges instead of rising edges only).
`timescale 1ns/1ps
package ro_100_pkg;

   // Default oscillator count and the width of the oscillator index field.
   localparam int RO_NUM_DEFAULT = 100;
   localparam int RO_SEL_W       = 7;

   // Measurement sequencer states.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      GATE   = 2'd2,
      DONE   = 2'd3
   } ro_gate_state_e;

   // The selected oscillator is powered while settling and while gating.
   function automatic logic is_active(input ro_gate_state_e s);
      return (s == SETTLE) || (s == GATE);
   endfunction

endpackage

// File: rtl/ro_tap_sync.sv
// ro_tap_sync: 2-FF synchroniser plus edge register for one asynchronous
// oscillator tap. Rising edges are reported by default; with the macro
// RO_GATE_BOTH_EDGES_EN defined, both edges are reported.
// While clear is high the edge register keeps tracking the synchronised
// tap but no edge is reported, so the first gate cycle cannot see a stale
// transition left over from the previously selected tap.
`timescale 1ns/1ps
module ro_tap_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic tap,
   input  logic clear,
   output logic hit
);

   logic meta_q;
   logic sync_q;
   logic prev_q;

   // Two-stage synchroniser followed by the edge (previous-sample) register.
   // NOTE: non-blocking assignments make all three flops sample the old
   // value of their predecessor; blocking ones would collapse the chain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         prev_q <= 1'b0;
      end else begin
         meta_q <= tap;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   // Edge detect on the synchronised tap, suppressed while clear is high.
   always_comb begin
`ifdef RO_GATE_BOTH_EDGES_EN
      hit = !clear && (sync_q ^ prev_q);
`else
      hit = !clear && sync_q && !prev_q;
`endif
   end

endmodule

// File: rtl/ro_gate_counter.sv
// ro_gate_counter: enables one ring oscillator, lets it settle, then counts
// its synchronised edges over a gate of gate_len ACLK cycles.
// Optional feature macro: RO_GATE_BOTH_EDGES_EN (handled in ro_tap_sync;
// counts both edges, timing and saturation unchanged).
// GATE_W defaults to CNT_W; it exists so a narrow counter can still be
// driven with a gate long enough to reach saturation.
`timescale 1ns/1ps
module ro_gate_counter
   import ro_100_pkg::*;
#(
   parameter int NUM_RO     = RO_NUM_DEFAULT,
   parameter int CNT_W      = 32,
   parameter int SETTLE_CYC = 4,
   parameter int GATE_W     = CNT_W
) (
   input  logic                ACLK,
   input  logic                ARESETN,
   input  logic                start,
   input  logic [RO_SEL_W-1:0] ro_sel,
   input  logic [GATE_W-1:0]   gate_len,
   input  logic [NUM_RO-1:0]   ro_tap,
   output logic [NUM_RO-1:0]   ro_en,
   output logic                busy,
   output logic                done,
   output logic [CNT_W-1:0]    count,
   output logic                overflow,
   output logic                sel_err
);

   // Phase timer must hold both the settle length and the gate length.
   localparam int SET_W = $clog2(SETTLE_CYC + 1);
   localparam int TMR_W = (GATE_W > SET_W) ? GATE_W : SET_W;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   ro_gate_state_e      state_q, state_d;
   logic [TMR_W-1:0]    tmr_q, tmr_d;
   logic [RO_SEL_W-1:0] sel_q, sel_d;
   logic [GATE_W-1:0]   gate_q;
   logic [CNT_W-1:0]    count_q;
   logic                overflow_q;
   logic                sel_err_q;
   logic [NUM_RO-1:0]   ro_en_q, ro_en_d;
   logic                accept;
   logic                sel_ok;
   logic                tap_mux;
   logic                tap_hit;

   assign accept = (state_q == IDLE) && start;
   assign sel_ok = int'(ro_sel) < NUM_RO;
   assign sel_d  = accept ? ro_sel : sel_q;

   // Next-state and phase-timer logic for the measurement sequence.
   // NOTE: every output of this block gets a default first, so no path
   // through the case statement can leave a latch behind.
   always_comb begin
      state_d = state_q;
      tmr_d   = tmr_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               if (sel_ok) begin
                  state_d = SETTLE;
                  tmr_d   = TMR_W'(SETTLE_CYC - 1);
               end else begin
                  state_d = DONE;
               end
            end
         end
         SETTLE: begin
            if (tmr_q == '0) begin
               if (gate_q == '0) begin
                  state_d = DONE;
               end else begin
                  state_d = GATE;
                  tmr_d   = TMR_W'(gate_q) - TMR_W'(1);
               end
            end else begin
               tmr_d = tmr_q - TMR_W'(1);
            end
         end
         GATE: begin
            if (tmr_q == '0) begin
               state_d = DONE;
            end else begin
               tmr_d = tmr_q - TMR_W'(1);
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State and phase-timer registers.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state_q <= IDLE;
         tmr_q   <= '0;
      end else begin
         state_q <= state_d;
         tmr_q   <= tmr_d;
      end
   end

   // One-hot enable for the next cycle, registered so the oscillator
   // enables never glitch while state and index change together.
   always_comb begin
      ro_en_d = '0;
      for (int i = 0; i < NUM_RO; i++) begin
         ro_en_d[i] = is_active(state_d) && (int'(sel_d) == i);
      end
   end

   // Tap mux on the latched index; out-of-range indices read as 0.
   always_comb begin
      tap_mux = 1'b0;
      for (int i = 0; i < NUM_RO; i++) begin
         if (int'(sel_q) == i) tap_mux = ro_tap[i];
      end
   end

   ro_tap_sync u_tap_sync (
      .clk   (ACLK),
      .rst_n (ARESETN),
      .tap   (tap_mux),
      .clear (state_q == SETTLE),
      .hit   (tap_hit)
   );

   // Request latching, saturating edge counter and status flags.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         sel_q      <= '0;
         gate_q     <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         sel_err_q  <= 1'b0;
         ro_en_q    <= '0;
      end else begin
         ro_en_q <= ro_en_d;
         if (accept) begin
            sel_q      <= ro_sel;
            gate_q     <= gate_len;
            count_q    <= '0;
            overflow_q <= 1'b0;
            sel_err_q  <= !sel_ok;
         end else if ((state_q == GATE) && tap_hit) begin
            if (count_q == CNT_MAX) begin
               overflow_q <= 1'b1;
            end else begin
               count_q <= count_q + CNT_W'(1);
            end
         end
      end
   end

   assign ro_en    = ro_en_q;
   assign busy     = (state_q != IDLE);
   assign done     = (state_q == DONE);
   assign count    = count_q;
   assign overflow = overflow_q;
   assign sel_err  = sel_err_q;

endmodule
